ws2812_driver: RTL and testbench
================================

Name: ws2812_driver

Overview:
- Serialises a frame of 24-bit colour words for a chain of WS2812 addressable LEDs onto a single one-wire NRZ output.
- Sits between the frame/pattern generator, which supplies a flat `data` vector and a `start` request, and the LED strip data pin.
- After the last bit it holds the line low for the latch (reset) interval.
- `busy` tells upstream logic when a new frame may be requested.

Parameters:
- LED_COUNT, 8, number of LEDs in the chain; frame length is LED_COUNT*24 bits.
- T0H_CYCLES, 20, high time of a '0' bit in clk cycles (0.40 us at 50 MHz).
- T1H_CYCLES, 40, high time of a '1' bit in clk cycles (0.80 us at 50 MHz).
- BIT_CYCLES, 63, total bit period in clk cycles (1.26 us at 50 MHz).
- LATCH_CYCLES, 3000, low time after the frame (60 us at 50 MHz, > 50 us WS2812 reset).

Ports:
- clk  input  1  system clock, 50 MHz nominal; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame request, sampled every clk edge.
- data  input  LED_COUNT*24  frame contents; LED 0 = data[LED_COUNT*24-1 -: 24], LED n = next lower 24 bits.
- dout  output  1  WS2812 serial data line (registered).
- busy  output  1  high while a frame or its latch interval is in progress (registered).

Behaviour:
- Single clock. Reset is synchronous and active-high; `reset` is sampled on the rising edge of `clk`.
- Reset state: state=IDLE, dout=0, busy=0, counters=0.
- Reset has priority over everything. Reset mid-frame or mid-latch returns to IDLE on that edge: dout=0, busy=0, and the frame is abandoned.
- States are IDLE, SEND, LATCH.
- IDLE:
  - dout=0, busy=0.
  - If start=1 at an edge:
    - latch `data` into an internal shift register;
    - bit counter := 0, cycle counter := 0;
    - go to SEND; busy=1 and dout=1 from that edge.
  - A start pulse of exactly one clk cycle is sufficient. Longer pulses are equivalent; start need not be level-held.
- SEND:
  - The current bit is the MSB of the shift register. The whole vector goes out MSB first, so LED 0 goes first, each 24-bit word MSB first.
  - The driver is byte-order agnostic; the GRB ordering is the producer's responsibility.
  - Per bit: dout=1 for THx cycles (T1H_CYCLES if bit=1, else T0H_CYCLES), then dout=0 for BIT_CYCLES-THx cycles.
  - Cycle counter counts 0..BIT_CYCLES-1. At wrap: shift left by one, increment the bit counter, and drive dout=1 for the next bit.
  - After bit LED_COUNT*24-1 completes: go to LATCH, dout=0, cycle counter := 0.
- LATCH:
  - dout=0, busy=1 for LATCH_CYCLES cycles, then IDLE with busy=0.
- start while busy=1 is ignored and not queued.
- Because busy covers the latch, a start seen the first cycle busy falls always yields a valid latch gap between frames.
- Changes to `data` after the start edge do not affect the frame in progress.
- Timing:
  - busy high for exactly LED_COUNT*24*BIT_CYCLES + LATCH_CYCLES cycles (8 LEDs: 12096+3000 = 15096).
  - First dout rising edge coincides with busy rising.
- Counter widths: sized with $clog2 of BIT_CYCLES, LED_COUNT*24 and LATCH_CYCLES; no overflow for any legal parameters.
- Legal parameters require 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES and LED_COUNT >= 1.

Test Plan:
- Reset, then idle 10 cycles with start=0 -> dout=0 and busy=0 throughout.
- LED_COUNT=8 with data {FF0000,00FF00,0000FF,FF0000,00FF00,0000FF,FF0000,00FF00}; start high for 2 cycles -> busy rises on the first start edge and stays high 15096 cycles.
  - First 8 bits are '1': 40 cycles high, 23 low each.
  - Next 16 bits are '0': 20 high, 43 low each.
  - Then 60 us low.
- Single-cycle start pulse -> identical waveform to the 2-cycle case; no hang.
- Second start issued 20 cycles after busy falls -> a second identical frame; dout stays low for at least 3000+20 cycles between frames.
- start pulsed again and data changed mid-frame -> no restart, and the frame bits match the originally latched data.
- reset asserted at bit 50 of the frame -> next edge dout=0, busy=0. A subsequent start sends a full, correct frame from LED 0 bit 23.

Source files
------------

// File: rtl/ws2812_driver.sv
// ---------------------------------------------------------------------------
// ws2812_driver
//
// Serialises a frame of LED_COUNT 24-bit colour words onto the one-wire NRZ
// data line of a WS2812 LED chain, then holds the line low for the latch
// interval so the strip applies the new colours.
//
// Ports:
//   clk    in   system clock (50 MHz nominal), all logic on the rising edge
//   reset  in   synchronous, active-high reset; overrides everything
//   start  in   frame request; honoured only while idle, never queued
//   data   in   frame contents, LED 0 in the top 24 bits, each word MSB first
//   dout   out  registered WS2812 serial data line
//   busy   out  registered; high from the start edge to the end of the latch
// ---------------------------------------------------------------------------
module ws2812_driver #(
    parameter int LED_COUNT    = 8,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int BIT_CYCLES   = 63,
    parameter int LATCH_CYCLES = 3000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LED_COUNT*24-1:0] data,
    output logic                    dout,
    output logic                    busy
);

    localparam int FRAME_BITS = LED_COUNT * 24;

    // Counter widths; a one-bit floor keeps degenerate parameter sets legal.
    localparam int CYC_W = (BIT_CYCLES   > 1) ? $clog2(BIT_CYCLES)   : 1;
    localparam int BIT_W = (FRAME_BITS   > 1) ? $clog2(FRAME_BITS)   : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] T0H_CNT  = CYC_W'(T0H_CYCLES);
    localparam logic [CYC_W-1:0] T1H_CNT  = CYC_W'(T1H_CYCLES);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_LATCH
    } state_e;

    state_e                  state_q,   state_d;
    logic [FRAME_BITS-1:0]   shreg_q,   shreg_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CYC_W-1:0]        cyc_cnt_q, cyc_cnt_d;
    logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic                    dout_q,    dout_d;
    logic                    busy_q,    busy_d;
    logic [CYC_W-1:0]        th_cnt;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            lat_cnt_q <= '0;
            dout_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        lat_cnt_d = lat_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Snapshot the frame so later changes to data are ignored.
                    state_d   = ST_SEND;
                    shreg_d   = data;
                    bit_cnt_d = '0;
                    cyc_cnt_d = '0;
                end
            end

            ST_SEND: begin
                if (cyc_cnt_q == CYC_LAST) begin
                    cyc_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = ST_LATCH;
                        lat_cnt_d = '0;
                    end else begin
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CYC_ONE;
                end
            end

            ST_LATCH: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered outputs, derived from the next state so that dout and busy
    // change on the same edge as the state they describe.
    // -----------------------------------------------------------------------
    always_comb begin
        th_cnt = shreg_d[FRAME_BITS-1] ? T1H_CNT : T0H_CNT;
        dout_d = (state_d == ST_SEND) && (cyc_cnt_d < th_cnt);
        busy_d = (state_d != ST_IDLE);
    end

    assign dout = dout_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// ---------------------------------------------------------------------------
// tb_ws2812_driver
//
// Self-checking bench for ws2812_driver with the default 8-LED timing.
// A vector table covers reset/idle behaviour and the start edge; a frame
// table drives whole frames and checks every bit period, the latch length,
// the busy fall and the idle gap against waveforms computed from the
// WS2812 timing constants.
// ---------------------------------------------------------------------------
module tb_ws2812_driver;

    localparam int LED_COUNT  = 8;
    localparam int FRAME_BITS = LED_COUNT * 24;
    localparam int T0H        = 20;
    localparam int T1H        = 40;
    localparam int BITC       = 63;
    localparam int LATCH      = 3000;

    localparam logic [191:0] FRAME1 = {24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF0000,
                                       24'h00FF00, 24'h0000FF, 24'hFF0000, 24'h00FF00};
    localparam logic [191:0] FRAME2 = {24'h123456, 24'h89ABCD, 24'hF0F0F0, 24'h0F0F0F,
                                       24'h800001, 24'h7FFFFE, 24'hDEADBE, 24'hEF0055};

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [FRAME_BITS-1:0] data;
    logic                  dout;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;

    ws2812_driver #(
        .LED_COUNT   (LED_COUNT),
        .T0H_CYCLES  (T0H),
        .T1H_CYCLES  (T1H),
        .BIT_CYCLES  (BITC),
        .LATCH_CYCLES(LATCH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .data (data),
        .dout (dout),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic st;
        int   reps;
        logic exp_dout;
        logic exp_busy;
    } vec_t;

    typedef struct {
        logic [191:0] d;
        int           start_len;
        bit           disturb;
        int           abort_bit;
        int           gap_after;
    } frame_t;

    vec_t   vecs[8];
    frame_t frames[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input frame_t f, input int idx);
        logic [191:0] d;
        int           errs;
        int           th;
        int           lows;
        d     = f.d;
        data  = d;
        start = 1'b1;
        for (int b = 0; b < FRAME_BITS; b++) begin
            errs = 0;
            for (int c = 0; c < BITC; c++) begin
                if (b == 0 && c == f.start_len) start = 1'b0;
                if (f.disturb && b == 100 && c == 5) begin
                    start = 1'b1;
                    data  = ~d;
                end
                if (f.disturb && b == 100 && c == 6) start = 1'b0;
                if (b == f.abort_bit && c == 10) begin
                    reset = 1'b1;
                    tick();
                    check($sformatf("f%0d abort dout", idx), {31'd0, dout}, 32'd0);
                    check($sformatf("f%0d abort busy", idx), {31'd0, busy}, 32'd0);
                    reset = 1'b0;
                    errs  = 0;
                    for (int k = 0; k < 5; k++) begin
                        tick();
                        if (dout !== 1'b0 || busy !== 1'b0) errs++;
                    end
                    check($sformatf("f%0d post-abort idle bad_cycles", idx), errs, 0);
                    return;
                end
                tick();
                th = d[FRAME_BITS-1-b] ? T1H : T0H;
                if (dout !== (c < th) || busy !== 1'b1) errs++;
            end
            check($sformatf("f%0d bit%0d bad_cycles", idx, b), errs, 0);
        end

        lows = 0;
        for (int k = 0; k < LATCH; k++) begin
            tick();
            if (dout === 1'b0 && busy === 1'b1) lows++;
        end
        check($sformatf("f%0d latch low+busy cycles", idx), lows, LATCH);

        tick();
        check($sformatf("f%0d busy fall", idx), {31'd0, busy}, 32'd0);
        check($sformatf("f%0d dout after latch", idx), {31'd0, dout}, 32'd0);

        errs = 0;
        for (int k = 0; k < f.gap_after; k++) begin
            tick();
            if (dout !== 1'b0 || busy !== 1'b0) errs++;
        end
        check($sformatf("f%0d idle gap bad_cycles", idx), errs, 0);
    endtask

    initial begin
        // reset, start, repetitions, expected dout, expected busy
        vecs[0] = '{1'b1, 1'b0, 1,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 10, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1,  1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 2,  1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1,  1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 3,  1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1,  1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 3,  1'b0, 1'b0};

        // data, start length, mid-frame disturbance, abort bit, idle cycles after
        frames[0] = '{FRAME1, 2, 1'b0, -1, 19};
        frames[1] = '{FRAME1, 1, 1'b1, -1, 5};
        frames[2] = '{FRAME2, 1, 1'b0, 50, 0};
        frames[3] = '{FRAME2, 1, 1'b0, -1, 5};

        reset = 1'b1;
        start = 1'b0;
        data  = FRAME1;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                reset = vecs[i].rst;
                start = vecs[i].st;
                tick();
                check($sformatf("vec%0d.%0d dout", i, r), {31'd0, dout}, {31'd0, vecs[i].exp_dout});
                check($sformatf("vec%0d.%0d busy", i, r), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            end
        end
        reset = 1'b0;
        start = 1'b0;

        foreach (frames[i]) begin
            run_frame(frames[i], i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
